// File: rtl/ddr3_cache.sv
// Direct-mapped, write-back, write-allocate 256-bit line cache between a CPU line port and a DDR3 controller.
// Optional feature DDR3_CACHE_CALIB_WAIT_EN: hold in INIT after reset until the controller's first ctrl_ack_i.
module ddr3_cache #(
    parameter int INDEX_BITS = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic [255:0] data_o,
    input  logic         we_i,
    input  logic         rd_i,
    output logic         ack_o,
    output logic [31:0]  ctrl_addr_o,
    input  logic [255:0] ctrl_data_i,
    output logic [255:0] ctrl_data_o,
    output logic         ctrl_we_o,
    output logic         ctrl_rd_o,
    input  logic         ctrl_ack_i
);
    localparam int TAG_W = 27 - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, WB, FILL, ACK} state_t;

    state_t           state_q, state_d;
    logic [26:0]      laddr_q, laddr_d;
    logic [255:0]     wdata_q, wdata_d;
    logic             op_wr_q, op_wr_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic             ack_q, ack_d;
    logic [255:0]     data_q, data_d;
    logic [31:0]      ctrl_addr_q, ctrl_addr_d;
    logic [255:0]     ctrl_data_q, ctrl_data_d;
    logic             ctrl_we_q, ctrl_we_d;
    logic             ctrl_rd_q, ctrl_rd_d;

    logic [255:0]     line_q [LINES];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic             line_we;
    logic [255:0]     line_wdata;
    logic             tag_we;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic                  victim_dirty;
    logic                  clean_miss;
    logic                  unused_addr_lsbs;

    assign idx              = laddr_q[INDEX_BITS-1:0];
    assign tag              = laddr_q[26:INDEX_BITS];
    assign hit              = valid_q[idx] && (tag_q[idx] == tag);
    assign victim_dirty     = valid_q[idx] && dirty_q[idx];
    assign unused_addr_lsbs = ^addr_i[4:0];

    always_comb begin
        state_d     = state_q;
        laddr_d     = laddr_q;
        wdata_d     = wdata_q;
        op_wr_d     = op_wr_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        ack_d       = 1'b0;
        data_d      = data_q;
        ctrl_addr_d = ctrl_addr_q;
        ctrl_data_d = ctrl_data_q;
        ctrl_we_d   = ctrl_we_q;
        ctrl_rd_d   = ctrl_rd_q;
        line_we     = 1'b0;
        line_wdata  = wdata_q;
        tag_we      = 1'b0;
        clean_miss  = 1'b0;

        case (state_q)
            INIT: begin
                if (ctrl_ack_i) state_d = IDLE;
            end
            IDLE: begin
                if (we_i || rd_i) begin
                    laddr_d = addr_i[31:5];
                    wdata_d = data_i;
                    op_wr_d = we_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    if (op_wr_q) begin
                        line_we      = 1'b1;
                        dirty_d[idx] = 1'b1;
                    end else begin
                        data_d = line_q[idx];
                    end
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else if (victim_dirty) begin
                    ctrl_we_d   = 1'b1;
                    ctrl_addr_d = {tag_q[idx], idx, 5'b0};
                    ctrl_data_d = line_q[idx];
                    state_d     = WB;
                end else begin
                    clean_miss = 1'b1;
                end
            end
            WB: begin
                if (ctrl_ack_i) begin
                    ctrl_we_d    = 1'b0;
                    dirty_d[idx] = 1'b0;
                    clean_miss   = 1'b1;
                end
            end
            FILL: begin
                if (ctrl_ack_i) begin
                    line_we      = 1'b1;
                    line_wdata   = ctrl_data_i;
                    tag_we       = 1'b1;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    data_d       = ctrl_data_i;
                    ctrl_rd_d    = 1'b0;
                    ack_d        = 1'b1;
                    state_d      = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A full-line write needs no fetch: install it straight away; reads go to the controller.
        if (clean_miss) begin
            if (op_wr_q) begin
                line_we      = 1'b1;
                tag_we       = 1'b1;
                valid_d[idx] = 1'b1;
                dirty_d[idx] = 1'b1;
                ack_d        = 1'b1;
                state_d      = ACK;
            end else begin
                ctrl_rd_d   = 1'b1;
                ctrl_addr_d = {laddr_q, 5'b0};
                state_d     = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) line_q[idx] <= line_wdata;
        if (tag_we)  tag_q[idx]  <= tag;
    end

    always_ff @(posedge clk) begin
        laddr_q <= laddr_d;
        wdata_q <= wdata_d;
        op_wr_q <= op_wr_d;
        if (!rst) begin
`ifdef DDR3_CACHE_CALIB_WAIT_EN
            state_q     <= INIT;
`else
            state_q     <= IDLE;
`endif
            valid_q     <= '0;
            dirty_q     <= '0;
            ack_q       <= 1'b0;
            data_q      <= '0;
            ctrl_addr_q <= '0;
            ctrl_data_q <= '0;
            ctrl_we_q   <= 1'b0;
            ctrl_rd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            ack_q       <= ack_d;
            data_q      <= data_d;
            ctrl_addr_q <= ctrl_addr_d;
            ctrl_data_q <= ctrl_data_d;
            ctrl_we_q   <= ctrl_we_d;
            ctrl_rd_q   <= ctrl_rd_d;
        end
    end

    assign data_o      = data_q;
    assign ack_o       = ack_q;
    assign ctrl_addr_o = ctrl_addr_q;
    assign ctrl_data_o = ctrl_data_q;
    assign ctrl_we_o   = ctrl_we_q;
    assign ctrl_rd_o   = ctrl_rd_q;

endmodule

// File: tb/tb_ddr3_cache.sv
// Self-checking bench for ddr3_cache: transaction-level cache/DDR model, a controller responder and one compare process.
module tb_ddr3_cache;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic [255:0] data_o;
    logic         we_i;
    logic         rd_i;
    logic         ack_o;
    logic [31:0]  ctrl_addr_o;
    logic [255:0] ctrl_data_i;
    logic [255:0] ctrl_data_o;
    logic         ctrl_we_o;
    logic         ctrl_rd_o;
    logic         ctrl_ack_i;

    ddr3_cache #(.INDEX_BITS(6)) dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .we_i(we_i), .rd_i(rd_i), .ack_o(ack_o), .ctrl_addr_o(ctrl_addr_o),
        .ctrl_data_i(ctrl_data_i), .ctrl_data_o(ctrl_data_o), .ctrl_we_o(ctrl_we_o),
        .ctrl_rd_o(ctrl_rd_o), .ctrl_ack_i(ctrl_ack_i)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Backing store seen by the controller responder
    logic [255:0] ddr [logic [31:0]];
    int           resp_lat = 3;
    bit           resp_en = 1'b1;
    int           cal_req = 0;
    int           cal_done = 0;
    int           wb_done = 0;
    int           fill_done = 0;
    logic [31:0]  last_wb_addr = '0;
    logic [255:0] last_wb_data = '0;
    logic [31:0]  last_fill_addr = '0;

    // Cache model: 64 lines, index = (addr/32)%64, tag = addr/2048
    bit           m_valid [64];
    bit           m_dirty [64];
    logic [20:0]  m_tag   [64];
    logic [255:0] m_line  [64];
    logic [255:0] m_data_o;

    bit           mon_en = 1'b0;
    bit           exp_active = 1'b0;
    bit           exp_wb, exp_fill;
    logic [31:0]  exp_wb_addr, exp_fill_addr;
    logic [255:0] exp_wb_data;
    int           exp_lat;
    int           req_start, wb_base, fill_base;
    int           ack_cnt = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        chk(name, {224'd0, act}, {224'd0, req});
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        chk(name, {255'd0, act}, {255'd0, req});
    endtask

    function automatic logic [255:0] ddr_peek(input logic [31:0] a);
        if (ddr.exists(a)) return ddr[a];
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
            m_line[i]  = '0;
        end
        m_data_o = '0;
    endtask

    task automatic predict(input bit w, input logic [31:0] a, input logic [255:0] d);
        int idx;
        logic [20:0] tg;
        bit hit;
        idx = int'((a / 32) % 64);
        tg  = 21'(a / 2048);
        hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb        = !hit && m_valid[idx] && m_dirty[idx];
        exp_wb_addr   = 32'(m_tag[idx]) * 2048 + 32'(idx) * 32;
        exp_wb_data   = m_line[idx];
        exp_fill      = !hit && !w;
        exp_fill_addr = a - (a % 32);
        exp_lat       = 2 + resp_lat * ((exp_wb ? 1 : 0) + (exp_fill ? 1 : 0));
        if (w) begin
            m_line[idx]  = d;
            m_dirty[idx] = 1'b1;
        end else begin
            if (!hit) begin
                m_line[idx]  = ddr_peek(exp_fill_addr);
                m_dirty[idx] = 1'b0;
            end
            m_data_o = m_line[idx];
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
    endtask

    task automatic wait_ack(input int base);
        bit got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ack_o) begin
                got = 1'b1;
                break;
            end
        end
        chk1("ack_seen", got, 1'b1);
        @(negedge clk);
        we_i = 1'b0;
        rd_i = 1'b0;
        exp_active = 1'b0;
        repeat (3) @(negedge clk);
        chk32("ack_pulse_count", 32'(ack_cnt - base), 32'd1);
    endtask

    task automatic cpu_req(input bit w, input bit r, input logic [31:0] a, input logic [255:0] d);
        int base;
        predict(w, a, d);
        base = ack_cnt;
        wb_base = wb_done;
        fill_base = fill_done;
        @(negedge clk);
        addr_i = a;
        data_i = d;
        we_i = w;
        rd_i = r;
        req_start = cyc;
        exp_active = 1'b1;
        wait_ack(base);
    endtask

    // Controller responder: acks a held strobe after resp_lat cycles, or emits a calibration pulse.
    initial begin
        int busy = 0;
        ctrl_ack_i = 1'b0;
        ctrl_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            ctrl_ack_i = 1'b0;
            ctrl_data_i = {8{$urandom}};
            if (cal_done != cal_req) begin
                cal_done = cal_req;
                ctrl_ack_i = 1'b1;
            end else if (resp_en && rst && (ctrl_we_o || ctrl_rd_o)) begin
                busy++;
                if (busy >= resp_lat) begin
                    busy = 0;
                    ctrl_ack_i = 1'b1;
                    if (ctrl_we_o) begin
                        ddr[ctrl_addr_o] = ctrl_data_o;
                        last_wb_addr = ctrl_addr_o;
                        last_wb_data = ctrl_data_o;
                        wb_done++;
                    end else begin
                        ctrl_data_i = ddr_peek(ctrl_addr_o);
                        last_fill_addr = ctrl_addr_o;
                        fill_done++;
                    end
                end
            end else begin
                busy = 0;
            end
        end
    end

    // Compare process: per-cycle protocol checks and per-transaction result checks against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ack_o) ack_cnt++;
            if (ctrl_we_o || ctrl_rd_o) chk1("strobe_exclusive", ctrl_we_o && ctrl_rd_o, 1'b0);
            if (!exp_active && rst) begin
                chk1("idle_ack", ack_o, 1'b0);
                chk1("idle_ctrl_we", ctrl_we_o, 1'b0);
                chk1("idle_ctrl_rd", ctrl_rd_o, 1'b0);
            end
            if (exp_active && ctrl_we_o) begin
                chk1("wb_expected", ctrl_we_o, exp_wb);
                chk32("wb_addr", ctrl_addr_o, exp_wb_addr);
                chk("wb_data", ctrl_data_o, exp_wb_data);
            end
            if (exp_active && ctrl_rd_o) begin
                chk1("fill_expected", ctrl_rd_o, exp_fill);
                chk32("fill_addr", ctrl_addr_o, exp_fill_addr);
                if (exp_wb) chk32("wb_before_fill", 32'(wb_done - wb_base), 32'd1);
            end
            if (exp_active && ack_o) begin
                chk("ack_data_o", data_o, m_data_o);
                chk32("ack_latency", 32'(cyc - req_start), 32'(exp_lat));
                chk32("ack_wb_count", 32'(wb_done - wb_base), exp_wb ? 32'd1 : 32'd0);
                chk32("ack_fill_count", 32'(fill_done - fill_base), exp_fill ? 32'd1 : 32'd0);
            end
        end
    end

    initial begin
        int base;
        bit seen;
        rst = 1'b0;
        addr_i = '0;
        data_i = '0;
        we_i = 1'b0;
        rd_i = 1'b0;
        reset_model();
        ddr[32'h0000_0020] = {32{8'hAA}};
        ddr[32'h0000_0820] = {32{8'h55}};

        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        chk1("rst_ack_o", ack_o, 1'b0);
        chk1("rst_ctrl_we_o", ctrl_we_o, 1'b0);
        chk1("rst_ctrl_rd_o", ctrl_rd_o, 1'b0);
        chk("rst_data_o", data_o, 256'd0);
        chk32("rst_ctrl_addr_o", ctrl_addr_o, 32'd0);
        chk("rst_ctrl_data_o", ctrl_data_o, 256'd0);
        rst = 1'b1;
        @(negedge clk);

`ifdef DDR3_CACHE_CALIB_WAIT_EN
        // Requests before calibration completes are ignored.
        addr_i = 32'h0000_0040;
        rd_i = 1'b1;
        repeat (6) @(negedge clk);
        chk1("init_no_ctrl_rd", ctrl_rd_o, 1'b0);
        chk1("init_no_ack", ack_o, 1'b0);
        resp_lat = 3;
        predict(1'b0, 32'h0000_0040, '0);
        base = ack_cnt;
        wb_base = wb_done;
        fill_base = fill_done;
        cal_req++;
        req_start = cyc + 2;
        exp_active = 1'b1;
        wait_ack(base);
        chk32("calib_fill_addr", last_fill_addr, 32'h0000_0040);
`endif

        // A stray controller ack while idle must not start anything.
        cal_req++;
        repeat (4) @(negedge clk);

        resp_lat = 3;
        cpu_req(1'b0, 1'b1, 32'h0000_0020, '0);
        chk("read_miss_data", data_o, {32{8'hAA}});
        chk32("read_miss_fill_addr", last_fill_addr, 32'h0000_0020);
        cpu_req(1'b0, 1'b1, 32'h0000_0020, '0);
        chk("reread_hit_data", data_o, {32{8'hAA}});

        cpu_req(1'b1, 1'b0, 32'h0000_0020, {32{8'h11}});
        chk("write_hit_keeps_data_o", data_o, {32{8'hAA}});

        resp_lat = 2;
        cpu_req(1'b0, 1'b1, 32'h0000_0820, '0);
        chk32("evict_wb_addr", last_wb_addr, 32'h0000_0020);
        chk("evict_wb_data", last_wb_data, {32{8'h11}});
        chk32("evict_fill_addr", last_fill_addr, 32'h0000_0820);
        chk("evict_read_data", data_o, {32{8'h55}});

        resp_lat = 3;
        cpu_req(1'b1, 1'b0, 32'h0000_1000, {32{8'h3C}});
        cpu_req(1'b0, 1'b1, 32'h0000_1000, '0);
        chk("write_miss_readback", data_o, {32{8'h3C}});

        cpu_req(1'b1, 1'b1, 32'h0000_1000, {32{8'h77}});
        cpu_req(1'b0, 1'b1, 32'h0000_1000, '0);
        chk("we_priority_readback", data_o, {32{8'h77}});

        cpu_req(1'b1, 1'b0, 32'h0000_3000, {32{8'h99}});
        chk("write_miss_dirty_wb", ddr_peek(32'h0000_1000), {32{8'h77}});

        resp_lat = 1;
        cpu_req(1'b0, 1'b1, 32'h0000_1000, '0);
        chk32("roundtrip_wb_addr", last_wb_addr, 32'h0000_3000);
        chk("roundtrip_data", data_o, {32{8'h77}});

        // Reset while a fill is outstanding.
        resp_en = 1'b0;
        predict(1'b0, 32'h0000_2020, '0);
        wb_base = wb_done;
        fill_base = fill_done;
        @(negedge clk);
        addr_i = 32'h0000_2020;
        rd_i = 1'b1;
        req_start = cyc;
        exp_active = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ctrl_rd_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk1("midfill_rd_raised", seen, 1'b1);
        chk32("midfill_addr", ctrl_addr_o, 32'h0000_2020);
        rst = 1'b0;
        @(negedge clk);
        chk1("midfill_rd_dropped", ctrl_rd_o, 1'b0);
        chk1("midfill_no_ack", ack_o, 1'b0);
        rd_i = 1'b0;
        exp_active = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        reset_model();
        resp_en = 1'b1;
`ifdef DDR3_CACHE_CALIB_WAIT_EN
        cal_req++;
`endif
        repeat (4) @(negedge clk);

        resp_lat = 2;
        cpu_req(1'b0, 1'b1, 32'h0000_0820, '0);
        chk32("post_reset_refill_addr", last_fill_addr, 32'h0000_0820);
        chk("post_reset_refill_data", data_o, {32{8'h55}});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
